// File: rtl/cam_array_if.sv
// Request/response bundle between the command decoder and the CAM array.
interface cam_array_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  read_enable_i;
  logic [ADDR_WIDTH-1:0] read_index_i;
  logic                  write_enable_i;
  logic [ADDR_WIDTH-1:0] write_index_i;
  logic [WIDTH-1:0]      write_data_i;
  logic                  search_enable_i;
  logic [WIDTH-1:0]      search_data_i;
  logic                  read_valid_o;
  logic [WIDTH-1:0]      read_data_o;
  logic                  read_hit_o;
  logic                  search_valid_o;
  logic                  search_hit_o;
  logic                  search_multi_o;
  logic [ADDR_WIDTH-1:0] search_index_o;
  logic                  drop_o;

  // Requester side: drives commands, receives results.
  modport master (
    output read_enable_i, read_index_i, write_enable_i, write_index_i, write_data_i,
           search_enable_i, search_data_i,
    input  read_valid_o, read_data_o, read_hit_o, search_valid_o, search_hit_o,
           search_multi_o, search_index_o, drop_o
  );

  // CAM side: receives commands, drives results.
  modport slave (
    input  read_enable_i, read_index_i, write_enable_i, write_index_i, write_data_i,
           search_enable_i, search_data_i,
    output read_valid_o, read_data_o, read_hit_o, search_valid_o, search_hit_o,
           search_multi_o, search_index_o, drop_o
  );
endinterface

// File: rtl/cam_array.sv
// CAM storage and match engine: one read, write or search per cycle.
// Read data returns after one cycle; search results after a 2-stage pipeline.
module cam_array #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input logic        clk_i,
  input logic        reset_i,
  cam_array_if.slave cam_bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH-1:0]      r_valid;

  logic                  w_rd;
  logic                  w_wr;
  logic                  w_sr;
  logic                  w_drop;
  logic [DEPTH-1:0]      w_match;

  logic                  r_s1_valid;
  logic [DEPTH-1:0]      r_s1_match;
  logic                  w_hit;
  logic                  w_multi;
  logic [ADDR_WIDTH-1:0] w_index;

  logic                  r_read_valid;
  logic [WIDTH-1:0]      r_read_data;
  logic                  r_read_hit;
  logic                  r_search_valid;
  logic                  r_search_hit;
  logic                  r_search_multi;
  logic [ADDR_WIDTH-1:0] r_search_index;
  logic                  r_drop;

  // Fixed priority read > write > search; a drop is any second asserted request.
  always_comb begin
    w_rd   = cam_bus.read_enable_i;
    w_wr   = cam_bus.write_enable_i & ~cam_bus.read_enable_i;
    w_sr   = cam_bus.search_enable_i & ~cam_bus.read_enable_i & ~cam_bus.write_enable_i;
    w_drop = (cam_bus.read_enable_i & (cam_bus.write_enable_i | cam_bus.search_enable_i)) |
             (cam_bus.write_enable_i & cam_bus.search_enable_i);
  end

  // Entry data is not reset; only the valid bits matter after reset.
  always_ff @(posedge clk_i) begin
    if (!reset_i && w_wr) begin
      r_mem[cam_bus.write_index_i] <= cam_bus.write_data_i;
    end
  end

  // Valid bits: cleared by reset, set by an accepted write.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_valid <= '0;
    end else if (w_wr) begin
      r_valid[cam_bus.write_index_i] <= 1'b1;
    end
  end

  // Parallel compare of the key against every valid entry.
  always_comb begin
    w_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_match[i] = r_valid[i] && (r_mem[i] == cam_bus.search_data_i);
    end
  end

  // Search stage 1: capture the match vector.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_s1_valid <= 1'b0;
      r_s1_match <= '0;
    end else begin
      r_s1_valid <= w_sr;
      if (w_sr) begin
        r_s1_match <= w_match;
      end
    end
  end

  // Priority encode to the lowest set index; multi when more than one bit is set.
  always_comb begin
    w_index = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (r_s1_match[i]) begin
        w_index = ADDR_WIDTH'(i);
      end
    end
    w_hit   = |r_s1_match;
    w_multi = |(r_s1_match & (r_s1_match - DEPTH'(1)));
  end

  // Search stage 2: register the encoded result; fields hold between results.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_search_valid <= 1'b0;
      r_search_hit   <= 1'b0;
      r_search_multi <= 1'b0;
      r_search_index <= '0;
    end else begin
      r_search_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_search_hit   <= w_hit;
        r_search_multi <= w_multi;
        r_search_index <= w_index;
      end
    end
  end

  // Read response and drop flag, both one cycle after the request.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_read_valid <= 1'b0;
      r_read_data  <= '0;
      r_read_hit   <= 1'b0;
      r_drop       <= 1'b0;
    end else begin
      r_read_valid <= w_rd;
      r_drop       <= w_drop;
      if (w_rd) begin
        r_read_data <= r_mem[cam_bus.read_index_i];
        r_read_hit  <= r_valid[cam_bus.read_index_i];
      end
    end
  end

  assign cam_bus.read_valid_o   = r_read_valid;
  assign cam_bus.read_data_o    = r_read_data;
  assign cam_bus.read_hit_o     = r_read_hit;
  assign cam_bus.search_valid_o = r_search_valid;
  assign cam_bus.search_hit_o   = r_search_hit;
  assign cam_bus.search_multi_o = r_search_multi;
  assign cam_bus.search_index_o = r_search_index;
  assign cam_bus.drop_o         = r_drop;
endmodule

// File: tb/tb_cam_array.sv
// Directed bench for cam_array with hand-computed expectations.
module tb_cam_array;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  cam_array_if #(.WIDTH(32), .ADDR_WIDTH(5)) u_if ();

  cam_array #(.WIDTH(32), .ADDR_WIDTH(5)) u_dut (
    .clk_i   (clk),
    .reset_i (rst),
    .cam_bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    u_if.read_enable_i   = 1'b0;
    u_if.write_enable_i  = 1'b0;
    u_if.search_enable_i = 1'b0;
  endtask

  task automatic wr(input logic [4:0] idx, input logic [31:0] d);
    u_if.write_enable_i = 1'b1;
    u_if.write_index_i  = idx;
    u_if.write_data_i   = d;
    tick();
    u_if.write_enable_i = 1'b0;
  endtask

  // Leaves outputs showing the read response.
  task automatic rd(input logic [4:0] idx);
    u_if.read_enable_i = 1'b1;
    u_if.read_index_i  = idx;
    tick();
    u_if.read_enable_i = 1'b0;
  endtask

  // Leaves outputs showing the search result (two cycles after acceptance).
  task automatic srch(input logic [31:0] key);
    u_if.search_enable_i = 1'b1;
    u_if.search_data_i   = key;
    tick();
    u_if.search_enable_i = 1'b0;
    tick();
  endtask

  task automatic check_search(input string tag, input logic hit, input logic multi,
                              input logic [4:0] idx);
    check_eq({tag, ".valid"}, 32'(u_if.search_valid_o), 32'd1);
    check_eq({tag, ".hit"},   32'(u_if.search_hit_o),   32'(hit));
    check_eq({tag, ".multi"}, 32'(u_if.search_multi_o), 32'(multi));
    check_eq({tag, ".index"}, 32'(u_if.search_index_o), 32'(idx));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle();
    u_if.read_index_i  = '0;
    u_if.write_index_i = '0;
    u_if.write_data_i  = '0;
    u_if.search_data_i = '0;

    // Reset with a write presented; it must be ignored.
    rst = 1'b1;
    u_if.write_enable_i = 1'b1;
    u_if.write_index_i  = 5'd6;
    u_if.write_data_i   = 32'h66;
    tick();
    tick();
    idle();
    check_eq("rst.read_valid",   32'(u_if.read_valid_o),   32'd0);
    check_eq("rst.read_data",    u_if.read_data_o,         32'd0);
    check_eq("rst.search_valid", 32'(u_if.search_valid_o), 32'd0);
    check_eq("rst.search_index", 32'(u_if.search_index_o), 32'd0);
    check_eq("rst.drop",         32'(u_if.drop_o),         32'd0);
    rst = 1'b0;
    rd(5'd6);
    check_eq("rst_write_ignored.hit", 32'(u_if.read_hit_o), 32'd0);

    // Search on an empty array.
    u_if.search_enable_i = 1'b1;
    u_if.search_data_i   = 32'h0;
    tick();
    u_if.search_enable_i = 1'b0;
    check_eq("empty.latency", 32'(u_if.search_valid_o), 32'd0);
    tick();
    check_search("empty", 1'b0, 1'b0, 5'd0);
    tick();
    check_eq("empty.pulse", 32'(u_if.search_valid_o), 32'd0);

    // Write then read back; neighbouring entry is invalid.
    wr(5'd3, 32'hDEADBEEF);
    rd(5'd3);
    check_eq("rd3.valid", 32'(u_if.read_valid_o), 32'd1);
    check_eq("rd3.data",  u_if.read_data_o,       32'hDEADBEEF);
    check_eq("rd3.hit",   32'(u_if.read_hit_o),   32'd1);
    tick();
    check_eq("rd3.pulse", 32'(u_if.read_valid_o), 32'd0);
    check_eq("rd3.hold",  u_if.read_data_o,       32'hDEADBEEF);
    rd(5'd4);
    check_eq("rd4.hit", 32'(u_if.read_hit_o), 32'd0);

    // Multiple matches, lowest index wins; overwrite moves the winner.
    wr(5'd7, 32'hA5A5A5A5);
    wr(5'd2, 32'hA5A5A5A5);
    wr(5'd31, 32'hA5A5A5A5);
    srch(32'hA5A5A5A5);
    check_search("multi1", 1'b1, 1'b1, 5'd2);
    wr(5'd2, 32'h0);
    srch(32'hA5A5A5A5);
    check_search("multi2", 1'b1, 1'b1, 5'd7);
    tick();
    check_eq("multi2.hold", 32'(u_if.search_index_o), 32'd7);

    // Top index as a single match.
    wr(5'd31, 32'h77);
    srch(32'h77);
    check_search("top", 1'b1, 1'b0, 5'd31);
    rd(5'd31);
    check_eq("rd31.data", u_if.read_data_o, 32'h77);

    // All three requests at once: only the read runs.
    u_if.read_enable_i   = 1'b1;
    u_if.read_index_i    = 5'd5;
    u_if.write_enable_i  = 1'b1;
    u_if.write_index_i   = 5'd5;
    u_if.write_data_i    = 32'h1;
    u_if.search_enable_i = 1'b1;
    u_if.search_data_i   = 32'h1;
    tick();
    idle();
    check_eq("arb.read_valid", 32'(u_if.read_valid_o), 32'd1);
    check_eq("arb.drop",       32'(u_if.drop_o),       32'd1);
    check_eq("arb.read_hit",   32'(u_if.read_hit_o),   32'd0);
    tick();
    check_eq("arb.drop_pulse",   32'(u_if.drop_o),         32'd0);
    check_eq("arb.no_search",    32'(u_if.search_valid_o), 32'd0);
    rd(5'd5);
    check_eq("arb.no_write", 32'(u_if.read_hit_o), 32'd0);

    // Write + search: write wins, search dropped.
    u_if.write_enable_i  = 1'b1;
    u_if.write_index_i   = 5'd9;
    u_if.write_data_i    = 32'h99;
    u_if.search_enable_i = 1'b1;
    u_if.search_data_i   = 32'h99;
    tick();
    idle();
    check_eq("ws.drop",       32'(u_if.drop_o),       32'd1);
    check_eq("ws.read_valid", 32'(u_if.read_valid_o), 32'd0);
    tick();
    check_eq("ws.no_search", 32'(u_if.search_valid_o), 32'd0);

    // Write visible to a search in the next cycle.
    wr(5'd0, 32'h11);
    srch(32'h11);
    check_search("wr_then_srch", 1'b1, 1'b0, 5'd0);

    // Back-to-back searches give back-to-back results.
    u_if.search_enable_i = 1'b1;
    u_if.search_data_i   = 32'h11;
    tick();
    u_if.search_data_i   = 32'h22;
    tick();
    idle();
    check_search("b2b1", 1'b1, 1'b0, 5'd0);
    tick();
    check_search("b2b2", 1'b0, 1'b0, 5'd0);

    // Search then read: both responses land in the same cycle.
    u_if.search_enable_i = 1'b1;
    u_if.search_data_i   = 32'h11;
    tick();
    idle();
    rd(5'd0);
    check_eq("both.search_valid", 32'(u_if.search_valid_o), 32'd1);
    check_eq("both.read_valid",   32'(u_if.read_valid_o),   32'd1);
    check_eq("both.read_data",    u_if.read_data_o,         32'h11);

    // Reset mid-search: the in-flight result never appears.
    u_if.search_enable_i = 1'b1;
    u_if.search_data_i   = 32'h11;
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst.valid0", 32'(u_if.search_valid_o), 32'd0);
    tick();
    check_eq("midrst.valid1", 32'(u_if.search_valid_o), 32'd0);
    srch(32'h11);
    check_search("after_rst", 1'b0, 1'b0, 5'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
